cbb_pulse_sync_scheduler: RTL and testbench

//  Shares one CBB pulse-synchronizer channel among P_NUM_REQ requesters in the source clock domain.

---
 rtl/cbb_pulse_sched_pkg.sv | 29 ++
 rtl/cbb_rr_pick.sv | 45 ++++
 rtl/cbb_pulse_sync_scheduler.sv | 115 +++++++++++
 tb/tb_cbb_pulse_sync_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cbb_pulse_sched_pkg.sv
// Shared definitions for the pulse-synchronizer scheduler: FSM encoding,
// a constant clog2 helper and a parameter sanity predicate.
package cbb_pulse_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } sched_state_e;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int num_req, input int id_w,
                                    input int gap_cycles, input int cnt_w);
      return (num_req >= 2) && (num_req <= 16) && (id_w >= clog2(num_req)) &&
             (gap_cycles >= 1) && (cnt_w >= 1);
   endfunction

endpackage

// File: rtl/cbb_rr_pick.sv
// Combinational round-robin picker: first set request found at last+1, last+2, ...
// wrapping modulo P_NUM_REQ.
module cbb_rr_pick #(
   parameter int P_NUM_REQ = 4,
   parameter int P_ID_W    = 2
) (
   input  logic [P_NUM_REQ-1:0] i_req,
   input  logic [P_ID_W-1:0]    i_last,
   output logic [P_NUM_REQ-1:0] o_grant,
   output logic [P_ID_W-1:0]    o_grant_idx,
   output logic                 o_valid
);

   function automatic logic [P_ID_W-1:0] wrap_idx(input logic [P_ID_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= P_NUM_REQ) s = s - P_NUM_REQ;
      return P_ID_W'(s);
   endfunction

   logic [P_ID_W-1:0] cand_idx [P_NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < P_NUM_REQ; gi++) begin : g_cand
         assign cand_idx[gi] = wrap_idx(i_last, gi + 1);
      end
   endgenerate

   // Scan from lowest to highest priority so the nearest candidate wins last.
   always_comb begin
      o_grant     = '0;
      o_grant_idx = '0;
      o_valid     = 1'b0;
      for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[cand_idx[k]]) begin
            o_grant                = '0;
            o_grant[cand_idx[k]]   = 1'b1;
            o_grant_idx            = cand_idx[k];
            o_valid                = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cbb_pulse_sync_scheduler.sv
// Shares one pulse-synchronizer channel among several requesters: latches events,
// grants them round-robin and spaces issues by a guard gap so pulses never merge.
module cbb_pulse_sync_scheduler
   import cbb_pulse_sched_pkg::*;
#(
   parameter int P_NUM_REQ    = 4,
   parameter int P_ID_W       = 2,
   parameter int P_GAP_CYCLES = 8,
   parameter int P_CNT_W      = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic [P_NUM_REQ-1:0] i_req_pulse,
   output logic                 o_sync_pulse,
   output logic [P_ID_W-1:0]    o_sync_id,
   output logic                 o_busy,
   output logic [P_NUM_REQ-1:0] o_pending,
   output logic [P_NUM_REQ-1:0] o_drop_pulse,
   output logic [P_CNT_W-1:0]   o_drop_cnt
);

   localparam int GW = clog2(P_GAP_CYCLES + 1);
   localparam int SW = P_CNT_W + 5;

   generate
      if (!params_ok(P_NUM_REQ, P_ID_W, P_GAP_CYCLES, P_CNT_W)) begin : g_bad_params
         $error("cbb_pulse_sync_scheduler: parameter out of range");
      end
   endgenerate

   sched_state_e         state_q;
   logic [GW-1:0]        gap_q;
   logic [P_NUM_REQ-1:0] pend_q, pend_d;
   logic [P_NUM_REQ-1:0] drop_q, drop_d;
   logic [P_CNT_W-1:0]   cnt_q, cnt_d;
   logic [P_ID_W-1:0]    last_q, id_q;
   logic                 pulse_q;

   logic [P_NUM_REQ-1:0] pick_grant, grant_eff;
   logic [P_ID_W-1:0]    pick_idx;
   logic                 pick_valid;
   logic                 can_issue;
   logic [SW-1:0]        drop_pop, cnt_sum;

   cbb_rr_pick #(
      .P_NUM_REQ (P_NUM_REQ),
      .P_ID_W    (P_ID_W)
   ) u_pick (
      .i_req       (pend_q),
      .i_last      (last_q),
      .o_grant     (pick_grant),
      .o_grant_idx (pick_idx),
      .o_valid     (pick_valid)
   );

   always_comb begin
      can_issue = i_enable && pick_valid &&
                  ((state_q == ST_IDLE) || ((state_q == ST_GAP) && (gap_q == '0)));
      grant_eff = can_issue ? pick_grant : '0;
      // A request landing on its own grant edge is a fresh event, not a drop.
      drop_d    = i_req_pulse & pend_q & ~grant_eff;
      pend_d    = (pend_q & ~grant_eff) | i_req_pulse;
      drop_pop  = '0;
      for (int k = 0; k < P_NUM_REQ; k++) begin
         drop_pop = drop_pop + SW'(drop_d[k]);
      end
      cnt_sum = SW'(cnt_q) + drop_pop;
      cnt_d   = (cnt_sum > SW'({P_CNT_W{1'b1}})) ? {P_CNT_W{1'b1}} : cnt_sum[P_CNT_W-1:0];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         gap_q   <= '0;
         pend_q  <= '0;
         drop_q  <= '0;
         cnt_q   <= '0;
         last_q  <= P_ID_W'(P_NUM_REQ - 1);
         id_q    <= '0;
         pulse_q <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
         pulse_q <= 1'b0;
         if (can_issue) begin
            state_q <= ST_ISSUE;
            pulse_q <= 1'b1;
            id_q    <= pick_idx;
            last_q  <= pick_idx;
         end else begin
            case (state_q)
               ST_ISSUE: begin
                  state_q <= ST_GAP;
                  gap_q   <= GW'(P_GAP_CYCLES - 1);
               end
               ST_GAP: begin
                  if (gap_q != '0) gap_q <= gap_q - 1'b1;
                  else             state_q <= ST_IDLE;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign o_sync_pulse = pulse_q;
   assign o_sync_id    = id_q;
   assign o_busy       = (state_q != ST_IDLE);
   assign o_pending    = pend_q;
   assign o_drop_pulse = drop_q;
   assign o_drop_cnt   = cnt_q;

endmodule

// File: tb/tb_cbb_pulse_sync_scheduler.sv
// Directed and randomized bench for cbb_pulse_sync_scheduler against a cooldown-based
// behavioural model of the scheduling rules.
module tb_cbb_pulse_sync_scheduler;

   localparam int N   = 4;
   localparam int GAP = 8;
   localparam int CW  = 8;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic [N-1:0]  req_pulse = '0;
   logic          sync_pulse;
   logic [1:0]    sync_id;
   logic          busy;
   logic [N-1:0]  pending;
   logic [N-1:0]  drop_pulse;
   logic [CW-1:0] drop_cnt;

   always #5 clk = ~clk;

   cbb_pulse_sync_scheduler #(
      .P_NUM_REQ    (N),
      .P_ID_W       (2),
      .P_GAP_CYCLES (GAP),
      .P_CNT_W      (CW)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_enable     (enable),
      .i_req_pulse  (req_pulse),
      .o_sync_pulse (sync_pulse),
      .o_sync_id    (sync_id),
      .o_busy       (busy),
      .o_pending    (pending),
      .o_drop_pulse (drop_pulse),
      .o_drop_cnt   (drop_cnt)
   );

   int n_pass = 0;
   int n_total = 0;
   int n_fail = 0;
   int cyc = 0;

   // Reference model: pending set, pointer, and a cooldown of edges until the next issue is allowed.
   logic [N-1:0] m_pend;
   int           m_last;
   int           m_cool;
   int           m_cnt;
   logic [N-1:0] m_drop;
   logic         m_pulse;
   int           m_id;

   int last_pulse_cyc = -1000;
   logic [1:0] prev_id = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: cycle %0d got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic int m_pick();
      int c;
      for (int o = 1; o <= N; o++) begin
         c = (m_last + o) % N;
         if (m_pend[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_edge(input logic [N-1:0] r, input logic en, input logic rs);
      int g;
      logic [N-1:0] gv;
      if (rs) begin
         m_pend = '0; m_last = N - 1; m_cool = 0; m_cnt = 0;
         m_drop = '0; m_pulse = 1'b0; m_id = 0;
      end else begin
         if (m_cool > 0) m_cool--;
         g = -1;
         if (en && m_cool == 0 && m_pend != '0) g = m_pick();
         gv = '0;
         if (g >= 0) gv[g] = 1'b1;
         m_drop = r & m_pend & ~gv;
         m_cnt = m_cnt + $countones(m_drop);
         if (m_cnt > CMAX) m_cnt = CMAX;
         m_pend = (m_pend & ~gv) | r;
         m_pulse = (g >= 0);
         if (g >= 0) begin
            m_id = g; m_last = g; m_cool = GAP + 1;
         end
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic en, input logic rs);
      req_pulse = r;
      enable = en;
      rst = rs;
      @(posedge clk);
      model_edge(r, en, rs);
      #1;
      cyc++;
      chk("pulse", 32'(sync_pulse), 32'(m_pulse));
      chk("id", 32'(sync_id), 32'(m_id));
      chk("busy", 32'(busy), 32'(m_cool > 0));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
      if (rs) begin
         last_pulse_cyc = -1000;
      end else begin
         if (sync_pulse === 1'b1) begin
            chk("spacing", 32'((cyc - last_pulse_cyc) >= GAP + 1), 32'd1);
            last_pulse_cyc = cyc;
         end
         chk("id_change_on_issue", 32'((sync_id === prev_id) || (sync_pulse === 1'b1)), 32'd1);
      end
      prev_id = sync_id;
      $display("cyc=%0d rst=%0b en=%0b req=%b pulse=%0b id=%0d busy=%0b pend=%b drop=%b cnt=%0d",
               cyc, rs, en, r, sync_pulse, sync_id, busy, pending, drop_pulse, drop_cnt);
   endtask

   int pulses;
   int busy_cnt;
   int ids[$];
   int pcyc[$];

   initial begin
      // 1: single request latency, busy length, id hold
      step('0, 1'b1, 1'b1);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_id", 32'(sync_id), 32'd0);
      while (cyc < 9) step('0, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      chk("t1_no_early_pulse", 32'(sync_pulse), 32'd0);
      step('0, 1'b1, 1'b0);
      chk("t1_pulse", 32'(sync_pulse), 32'd1);
      chk("t1_id", 32'(sync_id), 32'd2);
      pulses = 1; busy_cnt = 1;
      for (int i = 0; i < 15; i++) begin
         step('0, 1'b1, 1'b0);
         if (sync_pulse === 1'b1) pulses++;
         if (busy === 1'b1) busy_cnt++;
      end
      chk("t1_one_pulse", 32'(pulses), 32'd1);
      chk("t1_busy_len", 32'(busy_cnt), 32'(GAP + 1));
      chk("t1_id_hold", 32'(sync_id), 32'd2);

      // 2: all four at once drain in order, GAP+1 apart
      step('0, 1'b1, 1'b1);
      step(4'b1111, 1'b1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         step('0, 1'b1, 1'b0);
         if (sync_pulse === 1'b1) begin
            ids.push_back(int'(sync_id));
            pcyc.push_back(cyc);
         end
      end
      chk("t2_count", 32'(ids.size()), 32'd4);
      for (int k = 0; k < ids.size(); k++) begin
         chk("t2_order", 32'(ids[k]), 32'(k));
         if (k > 0) chk("t2_gap", 32'(pcyc[k] - pcyc[k-1]), 32'(GAP + 1));
      end
      chk("t2_drained", 32'(pending), 32'd0);

      // 3: drop while pending, then re-request on the grant edge
      step('0, 1'b1, 1'b1);
      step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      chk("t3_drop_pulse", 32'(drop_pulse), 32'b0010);
      chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
      step('0, 1'b1, 1'b0);
      chk("t3_drop_one_cycle", 32'(drop_pulse), 32'd0);
      while (m_cool > 1) step('0, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      chk("t3_grant_pulse", 32'(sync_pulse), 32'd1);
      chk("t3_grant_id", 32'(sync_id), 32'd1);
      chk("t3_repending", 32'(pending[1]), 32'd1);
      chk("t3_no_drop", 32'(drop_cnt), 32'd1);
      for (int i = 1; i <= GAP + 1; i++) begin
         step('0, 1'b1, 1'b0);
         chk("t3_reissue", 32'(sync_pulse), 32'(i == GAP + 1));
      end
      chk("t3_reissue_id", 32'(sync_id), 32'd1);

      // 4: enable low holds the issue
      step('0, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0);
      pulses = 0;
      for (int i = 0; i < 50; i++) begin
         step('0, 1'b0, 1'b0);
         if (sync_pulse === 1'b1) pulses++;
      end
      chk("t4_held", 32'(pulses), 32'd0);
      chk("t4_pending", 32'(pending), 32'b0100);
      pulses = 0;
      for (int i = 0; i < 2; i++) begin
         step('0, 1'b1, 1'b0);
         if (sync_pulse === 1'b1) pulses++;
      end
      chk("t4_issued", 32'(pulses), 32'd1);
      chk("t4_id", 32'(sync_id), 32'd2);

      // 5: reset in the middle of GAP
      step('0, 1'b1, 1'b1);
      step(4'b0001, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step(4'b1010, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("t5_in_gap", 32'(busy), 32'd1);
      step('0, 1'b1, 1'b1);
      chk("t5_rst_pend", 32'(pending), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_id", 32'(sync_id), 32'd0);
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         step('0, 1'b1, 1'b0);
         if (sync_pulse === 1'b1) pulses++;
      end
      chk("t5_no_pulse", 32'(pulses), 32'd0);
      step(4'b1000, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("t5_new_pulse", 32'(sync_pulse), 32'd1);
      chk("t5_new_id", 32'(sync_id), 32'd3);

      // 6: drop counter saturation
      step('0, 1'b0, 1'b1);
      step(4'b0001, 1'b0, 1'b0);
      for (int i = 0; i < 300; i++) step(4'b0001, 1'b0, 1'b0);
      chk("t6_saturated", 32'(drop_cnt), 32'(CMAX));

      // Randomized traffic with occasional resets
      step('0, 1'b1, 1'b1);
      for (int i = 0; i < 500; i++) begin
         step(($urandom_range(0, 3) == 0) ? N'($urandom) : N'(0),
              ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
